poly_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one quadratic evaluator (R = A·x² + B·x + C, 8-bit, Go/DataIn serial load protocol) among N requesters. Each requester presents all four operands in parallel. The arbiter grants one requester, replays its operands onto the evaluator's Go/DataIn handshake, waits for the evaluator's ResultValid, and returns the result with a one-hot Done pulse. A watchdog reports an error if the evaluator never answers.

---
 rtl/poly_arbiter_if.sv | 32 +++
 rtl/poly_arbiter.sv | 143 ++++++++++++++
 tb/tb_poly_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_arbiter_if.sv
// Request/result bundle between requesters, the arbiter and the evaluator.
// slave: arbiter side (requests + evaluator answers in, grants/results out).
// master: the side that raises requests and plays the evaluator.
interface poly_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    Req;
    logic [32*N-1:0] Operands;
    logic [N-1:0]    Done;
    logic            Error;
    logic [7:0]      Result;
    logic            Busy;
    logic [IW-1:0]   GrantId;
    logic            EvalGo;
    logic [7:0]      EvalData;
    logic            EvalValid;
    logic [7:0]      EvalResult;

    modport slave (
        input  Req, Operands, EvalValid, EvalResult,
        output Done, Error, Result, Busy, GrantId,
        output EvalGo, EvalData
    );

    modport master (
        output Req, Operands, EvalValid, EvalResult,
        input  Done, Error, Result, Busy, GrantId,
        input  EvalGo, EvalData
    );
endinterface

// File: rtl/poly_arbiter.sv
// Round-robin arbiter sharing one serial quadratic evaluator among N requesters.
// Ports: Clock, Resetn (async, active-low) and bus (poly_arbiter_if.slave).
module poly_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          Clock,
    input  logic          Resetn,
    poly_arbiter_if.slave bus
);
    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]     state;
    logic [IW-1:0]  ptr;
    logic [1:0]     k;
    logic [WDW-1:0] wd;
    logic [31:0]    op_q;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic           pick_ok;
    logic [IW-1:0]  pick_id;
    logic [31:0]    pick_ops;
    logic [7:0]     nxt_byte;
    logic [N-1:0]   grant_oh;

    // Rotate requests so bit 0 is the pointer slot; lowest set bit wins.
    always_comb begin
        dbl     = {bus.Req, bus.Req} >> ptr;
        rot     = dbl[N-1:0];
        pick_ok = 1'b0;
        off     = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_ok = 1'b1;
                off     = IW'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(N))
            sum = sum - (IW + 1)'(N);
        pick_id = sum[IW-1:0];
    end

    always_comb begin
        pick_ops = bus.Operands[31:0];
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == pick_id)
                pick_ops = bus.Operands[32*i +: 32];
        end
    end

    // Operand that follows the one just sent (order A, B, C, x).
    always_comb begin
        nxt_byte = op_q[7:0];
        case (k)
            2'd0:    nxt_byte = op_q[23:16];
            2'd1:    nxt_byte = op_q[15:8];
            default: nxt_byte = op_q[7:0];
        endcase
    end

    assign grant_oh = {{(N-1){1'b0}}, 1'b1} << bus.GrantId;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_IDLE;
            ptr          <= '0;
            k            <= '0;
            wd           <= '0;
            op_q         <= '0;
            bus.Done     <= '0;
            bus.Error    <= 1'b0;
            bus.Result   <= '0;
            bus.Busy     <= 1'b0;
            bus.GrantId  <= '0;
            bus.EvalGo   <= 1'b0;
            bus.EvalData <= '0;
        end else begin
            bus.Done <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        op_q         <= pick_ops;
                        bus.GrantId  <= pick_id;
                        bus.Busy     <= 1'b1;
                        k            <= '0;
                        bus.EvalGo   <= 1'b1;
                        bus.EvalData <= pick_ops[31:24];
                        state        <= S_HI;
                    end
                end
                S_HI: begin
                    bus.EvalGo <= 1'b0;
                    state      <= S_LO;
                end
                S_LO: begin
                    if (k == 2'd3) begin
                        wd    <= '0;
                        state <= S_WAIT;
                    end else begin
                        k            <= k + 2'd1;
                        bus.EvalGo   <= 1'b1;
                        bus.EvalData <= nxt_byte;
                        state        <= S_HI;
                    end
                end
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    // A real answer beats a simultaneous timeout.
                    if (bus.EvalValid) begin
                        bus.Result <= bus.EvalResult;
                        bus.Error  <= 1'b0;
                        bus.Done   <= grant_oh;
                        state      <= S_DONE;
                    end else if (wd == WD_LAST) begin
                        bus.Result <= '0;
                        bus.Error  <= 1'b1;
                        bus.Done   <= grant_oh;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.Busy <= 1'b0;
                    ptr      <= (bus.GrantId == IW'(N - 1)) ?
                                '0 : bus.GrantId + 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_arbiter.sv
// Scoreboard bench for poly_arbiter with a behavioural serial evaluator.
// Expected Go bytes and Done results are queued at stimulus time.
module tb_poly_arbiter;
    localparam int N  = 4;
    localparam int TO = 32;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } go_t;

    typedef struct {
        logic [3:0] done;
        int         id;
        logic [7:0] res;
        logic       err;
        int         cyc;
    } dn_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vec_cnt;
    int   err_cnt;
    go_t  go_q[$];
    dn_t  dn_q[$];

    poly_arbiter_if #(.N(N)) bus ();

    poly_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Evaluator: valid high while idle, dropped by A, answer 7 cycles after x.
    logic [7:0] ev_a, ev_b, ev_c, ev_x, ev_r;
    logic [1:0] ev_n;
    int         ev_cd;
    logic       ev_v;
    logic       ev_dead;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_n  <= '0;
            ev_cd <= 0;
            ev_v  <= 1'b1;
            ev_r  <= '0;
            ev_a  <= '0;
            ev_b  <= '0;
            ev_c  <= '0;
            ev_x  <= '0;
        end else begin
            if (bus.EvalGo) begin
                case (ev_n)
                    2'd0: begin
                        ev_a <= bus.EvalData;
                        ev_v <= 1'b0;
                    end
                    2'd1: ev_b <= bus.EvalData;
                    2'd2: ev_c <= bus.EvalData;
                    default: begin
                        ev_x  <= bus.EvalData;
                        ev_cd <= 6;
                    end
                endcase
                ev_n <= ev_n + 2'd1;
            end
            if (ev_cd != 0) begin
                ev_cd <= ev_cd - 1;
                if (ev_cd == 1) begin
                    ev_v <= 1'b1;
                    ev_r <= ev_a * ev_x * ev_x + ev_b * ev_x + ev_c;
                end
            end
        end
    end

    assign bus.EvalValid  = ev_v & ~ev_dead;
    assign bus.EvalResult = ev_r;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b,
                                         input int c, input int x);
        return {a[7:0], b[7:0], c[7:0], x[7:0]};
    endfunction

    function automatic logic [7:0] quad(input logic [31:0] o);
        int a, b, c, x, v;
        a = int'(o[31:24]);
        b = int'(o[23:16]);
        c = int'(o[15:8]);
        x = int'(o[7:0]);
        v = a * x * x + b * x + c;
        return 8'(v % 256);
    endfunction

    // t0 < 0: cycle numbers unknown, not checked.
    task automatic push_job(input int id, input logic [31:0] o,
                            input int t0, input logic err);
        go_t g;
        dn_t d;
        for (int m = 0; m < 4; m++) begin
            g.d   = o[31-8*m -: 8];
            g.cyc = (t0 < 0) ? -1 : t0 + 1 + 2 * m;
            go_q.push_back(g);
        end
        d.done = 4'b0001 << id;
        d.id   = id;
        d.res  = err ? 8'd0 : quad(o);
        d.err  = err;
        d.cyc  = (t0 < 0) ? -1 : t0 + (err ? 9 + TO : 15);
        dn_q.push_back(d);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.EvalGo) begin
                if (go_q.size() == 0) begin
                    chk("go_extra", 32'd1, 32'd0);
                end else begin
                    go_t g;
                    g = go_q.pop_front();
                    chk("go_data", bus.EvalData, g.d);
                    if (g.cyc >= 0)
                        chk("go_cyc", cyc, g.cyc);
                end
            end
            if (bus.Done != '0) begin
                if (dn_q.size() == 0) begin
                    chk("done_extra", bus.Done, 32'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("done_vec", bus.Done, d.done);
                    chk("grant_id", bus.GrantId, d.id);
                    chk("result", bus.Result, d.res);
                    chk("error", bus.Error, d.err);
                    chk("busy_done", bus.Busy, 1);
                    if (d.cyc >= 0)
                        chk("done_cyc", cyc, d.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.Done == '0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (bus.Done == '0)
            chk("wait_done", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] outs();
        return {bus.Done, bus.Error, bus.Result, bus.Busy,
                bus.GrantId, bus.EvalGo, bus.EvalData};
    endfunction

    initial begin
        #50000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int   t0;
        logic [31:0] o;
        go_t  g;
        cyc          = 0;
        vec_cnt      = 0;
        err_cnt      = 0;
        rst_n        = 1'b0;
        ev_dead      = 1'b0;
        bus.Req      = '0;
        bus.Operands = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        tick();

        // All four requesting continuously: 0,1,2,3,0 at 16-cycle spacing.
        bus.Operands[31:0]  = pack(1, 2, 3, 4);
        bus.Operands[63:32] = pack(5, 7, 9, 10);
        bus.Operands[95:64] = pack(3, 3, 3, 3);
        bus.Operands[127:96] = pack(2, 1, 0, 255);
        tick();
        t0 = cyc;
        bus.Req = 4'hF;
        for (int j = 0; j < 5; j++) begin
            o = bus.Operands[32*(j%4) +: 32];
            push_job(j % 4, o, t0 + 16 * j, 1'b0);
        end
        for (int j = 0; j < 5; j++)
            wait_done(40);
        bus.Req = '0;

        // Single request with cycle-exact Go/Done timing.
        tick();
        t0 = cyc;
        bus.Req = 4'b0001;
        push_job(0, pack(1, 2, 3, 4), t0, 1'b0);
        wait_done(40);
        bus.Req = '0;
        chk("single_res", bus.Result, 32'd27);
        @(negedge clk);
        chk("busy_after", bus.Busy, 32'd0);
        chk("gid_after", bus.GrantId, 32'd0);

        // Result wraps modulo 256.
        tick();
        t0 = cyc;
        bus.Req = 4'b0010;
        push_job(1, pack(5, 7, 9, 10), t0, 1'b0);
        wait_done(40);
        bus.Req = '0;
        chk("wrap_res", bus.Result, 32'd67);

        // Pointer rotation: 2 alone, then 1 and 3 together -> 3 first.
        tick();
        t0 = cyc;
        bus.Req = 4'b0100;
        push_job(2, pack(3, 3, 3, 3), t0, 1'b0);
        wait_done(40);
        bus.Req = 4'b1010;
        push_job(3, pack(2, 1, 0, 255), -1, 1'b0);
        push_job(1, pack(5, 7, 9, 10), -1, 1'b0);
        wait_done(40);
        bus.Req = 4'b0010;
        wait_done(40);
        bus.Req = '0;

        // Silent evaluator: timeout with Error, then normal service.
        tick();
        ev_dead = 1'b1;
        bus.Operands[31:0] = pack(9, 8, 7, 6);
        t0 = cyc;
        bus.Req = 4'b0001;
        push_job(0, pack(9, 8, 7, 6), t0, 1'b1);
        wait_done(TO + 40);
        bus.Req = '0;
        ev_dead = 1'b0;
        tick();
        bus.Operands[95:64] = pack(4, 3, 2, 1);
        t0 = cyc;
        bus.Req = 4'b0100;
        push_job(2, pack(4, 3, 2, 1), t0, 1'b0);
        wait_done(40);
        bus.Req = '0;
        chk("post_to_err", bus.Error, 32'd0);

        // Reset mid-job in cycle 5: outputs clear at once, no Done.
        tick();
        bus.Operands[31:0] = pack(1, 1, 1, 1);
        t0 = cyc;
        bus.Req = 4'b0001;
        g.d = 8'd1; g.cyc = t0 + 1; go_q.push_back(g);
        g.d = 8'd1; g.cyc = t0 + 3; go_q.push_back(g);
        for (int n = 0; n < 20 && cyc < t0 + 5; n++)
            tick();
        chk("pre_abort_go", bus.EvalGo, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(), 32'd0);
        bus.Req = '0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        bus.Operands[127:96] = pack(5, 7, 9, 10);
        t0 = cyc;
        bus.Req = 4'b1000;
        push_job(3, pack(5, 7, 9, 10), t0, 1'b0);
        wait_done(40);
        bus.Req = '0;

        repeat (5) tick();
        chk("go_q_empty", go_q.size(), 32'd0);
        chk("dn_q_empty", dn_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end
endmodule
